// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the sequential multiplier.
// Every Booth row generator uses the same x1/x2/neg recoding, so their rows agree bit for bit.
package booth_pkg;

   localparam int BOOTH_WIDTH = 16;
   localparam int STEPS       = BOOTH_WIDTH / 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic x1;
      logic x2;
      logic neg;
   } booth_digit_t;

   // A window of 111 decodes to zero with neg clear, so a d=0 row stays all-zero.
   function automatic booth_digit_t booth_digit(input logic [2:0] w);
      booth_digit_t d;
      d.x1  = w[1] ^ w[0];
      d.x2  = (w == 3'b011) || (w == 3'b100);
      d.neg = w[2] & ~(w[1] & w[0]);
      return d;
   endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Operand and product handshake bundle for booth_seq_multiplier.
import booth_pkg::*;

interface booth_seq_multiplier_if #(parameter int WIDTH = BOOTH_WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p
   );

endinterface

// File: rtl/booth_seq_multiplier_row_gen.sv
// Combinational radix-4 Booth row: one's-complement multiple of A plus a separate neg bit.
import booth_pkg::*;

module booth_row_gen #(
   parameter int WIDTH = BOOTH_WIDTH
) (
   input  logic [2:0]       i_w,
   input  logic [WIDTH-1:0] i_a,
   output logic [WIDTH:0]   o_pp,
   output logic             o_neg
);

   booth_digit_t     w_digit;
   logic [WIDTH:0]   w_mag;

   assign w_digit = booth_digit(i_w);

   // The row is one bit wider than A so that 2*(-2^(WIDTH-1)) inverts to 0_1..1 without overflow.
   always_comb begin
      w_mag = '0;
      if (w_digit.x1) begin
         w_mag = {i_a[WIDTH-1], i_a};
      end else if (w_digit.x2) begin
         w_mag = {i_a, 1'b0};
      end
   end

   assign o_pp  = w_digit.neg ? ~w_mag : w_mag;
   assign o_neg = w_digit.neg;

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth row per cycle accumulated into a 2*WIDTH product.
import booth_pkg::*;

module booth_seq_multiplier #(
   parameter int WIDTH = BOOTH_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   output logic                  busy,
   booth_seq_multiplier_if.slave bus
);

   localparam int NSTEPS = WIDTH / 2;
   localparam int SW     = $clog2(NSTEPS);

   state_t               r_state;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH:0]       r_bSh;
   logic [SW-1:0]        r_step;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_outP;
   logic                 r_outValid;
   logic                 r_busy;

   logic [WIDTH:0]       w_pp;
   logic                 w_neg;
   logic [2*WIDTH-1:0]   w_term;
   logic [2*WIDTH-1:0]   w_accNext;
   logic                 w_inReady;
   logic                 w_accept;
   logic                 w_lastStep;

   booth_row_gen #(.WIDTH(WIDTH)) u_rowGen (
      .i_w   (r_bSh[2:0]),
      .i_a   (r_a),
      .o_pp  (w_pp),
      .o_neg (w_neg)
   );

   // The neg bit completes the two's complement of the inverted row at the row's own weight.
   assign w_term = ({{(WIDTH-1){w_pp[WIDTH]}}, w_pp} + {{(2*WIDTH-1){1'b0}}, w_neg})
                   << {r_step, 1'b0};
   assign w_accNext  = r_acc + w_term;
   assign w_lastStep = (r_step == SW'(NSTEPS - 1));

   assign w_inReady = !flush && ((r_state == IDLE) || ((r_state == DONE) && bus.out_ready));
   assign w_accept  = w_inReady && bus.in_valid;

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_p     = r_outP;
   assign busy          = r_busy;

   // Accepting in DONE while the product handshakes reloads directly into RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_bSh      <= '0;
         r_step     <= '0;
         r_acc      <= '0;
         r_outP     <= '0;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
      end else if (flush) begin
         r_state    <= IDLE;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= bus.in_a;
                  r_bSh   <= {bus.in_b, 1'b0};
                  r_acc   <= '0;
                  r_step  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_acc  <= w_accNext;
               r_bSh  <= {r_bSh[WIDTH], r_bSh[WIDTH], r_bSh[WIDTH:2]};
               r_step <= r_step + 1'b1;
               if (w_lastStep) begin
                  r_outP     <= w_accNext;
                  r_outValid <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  if (w_accept) begin
                     r_a     <= bus.in_a;
                     r_bSh   <= {bus.in_b, 1'b0};
                     r_acc   <= '0;
                     r_step  <= '0;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomised checks of booth_seq_multiplier at WIDTH=16 against hand-computed products.
module tb_booth_seq_multiplier;

   logic clk;
   logic rst_n;
   logic flush;
   logic busy;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] expQ[$];

   booth_seq_multiplier_if #(.WIDTH(16)) bus ();

   booth_seq_multiplier #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .busy  (busy),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic accept(input logic [15:0] a, input logic [15:0] b, input string name);
      bit ok = 1'b0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("[TB] FAIL %s accept: in_ready never rose within 40 cycles", name);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cycles, output bit ok);
      cycles = 0;
      ok     = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
         cycles++;
      end
   endtask

   task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] expP, input string name);
      int  cyc;
      bit  ok;
      accept(a, b, name);
      wait_valid(cyc, ok);
      compared++;
      if (!ok || bus.out_p !== expP) begin
         mismatched++;
         $display("[TB] FAIL %s product: got %h (valid=%0d) want %h", name, bus.out_p, ok, expP);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      #2;
      compared++;
      if (bus.out_valid !== 1'b0 || bus.out_p !== 32'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_state: valid=%b p=%h busy=%b want 0/0/0",
                  bus.out_valid, bus.out_p, busy);
      end
      compared++;
      if (bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int cyc;
      bit ok;
      bus.out_ready = 1'b1;
      accept(16'd3, 16'd5, "basic");
      wait_valid(cyc, ok);
      compared++;
      if (!ok || cyc != 8) begin
         mismatched++;
         $display("[TB] FAIL basic_latency: got %0d cycles (valid=%0d) want 8", cyc, ok);
      end
      compared++;
      if (bus.out_p !== 32'h0000000F) begin
         mismatched++;
         $display("[TB] FAIL basic_product: got %h want 0000000f", bus.out_p);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL basic_drop: valid=%b busy=%b want 0/0", bus.out_valid, busy);
      end
   endtask

   task automatic test_corners();
      bus.out_ready = 1'b1;
      run_one(16'h8000, 16'h8000, 32'h40000000, "min_x_min");
      run_one(16'h7FFF, 16'h8000, 32'hC0008000, "max_x_min");
      run_one(16'hFFFF, 16'hFFFF, 32'h00000001, "m1_x_m1");
      run_one(16'h0000, 16'h1234, 32'h00000000, "zero_a");
   endtask

   task automatic test_backpressure();
      int cyc;
      bit ok;
      bit seenAgain = 1'b0;
      bus.out_ready = 1'b0;
      accept(16'd100, 16'hFFF9, "backpressure");
      wait_valid(cyc, ok);
      for (int i = 0; i < 5; i++) begin
         compared++;
         if (!bus.out_valid || bus.out_p !== 32'hFFFFFD44 || bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_hold[%0d]: valid=%b p=%h in_ready=%b want 1/fffffd44/0",
                     i, bus.out_valid, bus.out_p, bus.in_ready);
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL bp_release_ready: got %b want 1", bus.in_ready);
      end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.out_valid) seenAgain = 1'b1;
      end
      compared++;
      if (seenAgain) begin
         mismatched++;
         $display("[TB] FAIL bp_single: product delivered more than once");
      end
   endtask

   task automatic test_back_to_back();
      int   c1 = -1;
      int   c2 = -1;
      logic [31:0] p1 = '0;
      logic [31:0] p2 = '0;
      logic readyAtDone = 1'b0;
      logic validAfter  = 1'b1;
      bus.out_ready = 1'b1;
      accept(16'd5, 16'd6, "b2b_first");
      bus.in_a     = 16'hFFFC;
      bus.in_b     = 16'd9;
      bus.in_valid = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c1 >= 0 && c == c1 + 1) validAfter = bus.out_valid;
         if (bus.out_valid) begin
            if (c1 < 0) begin
               c1          = c;
               p1          = bus.out_p;
               readyAtDone = bus.in_ready;
            end else if (c > c1 + 1) begin
               c2 = c;
               p2 = bus.out_p;
               break;
            end
         end
         @(posedge clk);
         #1;
         if (c1 >= 0) bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      compared++;
      if (p1 !== 32'h0000001E || readyAtDone !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL b2b_first: p=%h in_ready=%b want 0000001e/1", p1, readyAtDone);
      end
      compared++;
      if (validAfter !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL b2b_gap: out_valid after first handshake %b want 0", validAfter);
      end
      compared++;
      if (c2 < 0 || c2 - c1 != 9 || p2 !== 32'hFFFFFFDC) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: spacing %0d p=%h want 9/ffffffdc", c2 - c1, p2);
      end
   endtask

   task automatic test_flush_reset();
      bit seen = 1'b0;
      bus.out_ready = 1'b1;
      accept(16'd7, 16'd7, "flush_run");
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_a     = 16'd1;
      bus.in_b     = 16'd1;
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL flush_cycle: in_ready=%b busy=%b want 0/1", bus.in_ready, busy);
      end
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL flush_idle: busy=%b in_ready=%b want 0/1", busy, bus.in_ready);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      compared++;
      if (seen) begin
         mismatched++;
         $display("[TB] FAIL flush_no_output: out_valid rose for a flushed product");
      end

      @(posedge clk);
      #1;
      flush        = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.in_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL flush_idle_ready: got %b want 0", bus.in_ready);
      end
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL flush_not_accepted: busy=%b want 0", busy);
      end

      accept(16'd9, 16'd9, "reset_run");
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_p !== 32'h0) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_run: busy=%b valid=%b p=%h want 0/0/0",
                  busy, bus.out_valid, bus.out_p);
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      compared++;
      if (seen) begin
         mismatched++;
         $display("[TB] FAIL reset_no_output: out_valid rose for an abandoned product");
      end
      @(posedge clk);
      #1;
      run_one(16'd2, 16'hFFFD, 32'hFFFFFFFA, "after_reset");
   endtask

   task automatic test_random(input int n);
      int recv = 0;
      bit stall = 1'b0;
      fork
         begin
            logic signed [15:0] sa;
            logic signed [15:0] sb;
            logic [31:0] e;
            bit got;
            for (int k = 0; k < n; k++) begin
               sa = 16'($urandom);
               sb = 16'($urandom);
               e  = sa * sb;
               bus.in_a     = sa;
               bus.in_b     = sb;
               bus.in_valid = 1'b1;
               got = 1'b0;
               for (int i = 0; i < 200; i++) begin
                  @(negedge clk);
                  if (bus.in_ready) begin
                     got = 1'b1;
                     break;
                  end
               end
               if (!got) begin
                  stall = 1'b1;
                  break;
               end
               expQ.push_back(e);
               @(posedge clk);
               #1;
            end
            bus.in_valid = 1'b0;
         end
         begin
            logic [31:0] e;
            for (int i = 0; i < 60000 && recv < n && !stall; i++) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               if (bus.out_valid && bus.out_ready) begin
                  compared++;
                  if (expQ.size() == 0) begin
                     mismatched++;
                     $display("[TB] FAIL rand_extra: product %h with nothing outstanding", bus.out_p);
                  end else begin
                     e = expQ.pop_front();
                     if (bus.out_p !== e) begin
                        mismatched++;
                        $display("[TB] FAIL rand_product[%0d]: got %h want %h", recv, bus.out_p, e);
                     end
                  end
                  recv++;
               end
            end
         end
      join
      compared++;
      if (stall || recv != n || expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL rand_count: received %0d of %0d, %0d outstanding, stall=%0d",
                  recv, n, expQ.size(), stall);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_backpressure();
      test_back_to_back();
      test_flush_reset();
      test_random(1500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
